// File: rtl/data_mem_resp.sv
// Data-memory responder: one word load/store per transaction with WAIT_CYCLES wait states.
// Optional byte-lane store strobes are enabled by defining DMEM_BYTE_STRB_EN.
module data_mem_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        lw_en,
  input  logic        sw_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_STRB_EN
  input  logic [3:0]  wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              lw_q, lw_d;
  logic              sw_q, sw_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic [AddrW-1:0]  idx;
  logic              bad_req;
  logic              commit;
  logic              mem_we;

  // Full 30-bit word index is range-checked so out-of-range addresses never alias.
  assign idx     = addr_q[AddrW+1:2];
  assign bad_req = (lw_q == sw_q) || (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH);
  assign commit  = (state_q == StWait) && (cnt_q == '0);
  assign mem_we  = commit && sw_q && !bad_req && !rst;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rdata     = rdata_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lw_d    = lw_q;
    sw_d    = sw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          lw_d    = lw_en;
          sw_d    = sw_en;
          addr_d  = addr;
          wdata_d = wdata;
`ifdef DMEM_BYTE_STRB_EN
          wstrb_d = wstrb;
`else
          wstrb_d = 4'hF;
`endif
          cnt_d   = CntW'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_d   = bad_req;
          rdata_d = (!bad_req && lw_q) ? mem_q[idx] : 32'h0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lw_q    <= 1'b0;
      sw_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lw_q    <= lw_d;
      sw_q    <= sw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; only lanes enabled by the captured strobe are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed, table-driven bench for data_mem_resp (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        lw_en, sw_en, rsp_ready;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        a_req_valid, b_req_valid;
  logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;

  bit          sel;
  logic        cur_req_ready, cur_rsp_valid, cur_err;
  logic [31:0] cur_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .lw_en     (lw_en),
    .sw_en     (sw_en),
    .addr      (addr),
    .wdata     (wdata),
`ifdef DMEM_BYTE_STRB_EN
    .wstrb     (wstrb),
`endif
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rdata     (a_rdata),
    .err       (a_err)
  );

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .lw_en     (lw_en),
    .sw_en     (sw_en),
    .addr      (addr),
    .wdata     (wdata),
`ifdef DMEM_BYTE_STRB_EN
    .wstrb     (wstrb),
`endif
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rdata     (b_rdata),
    .err       (b_err)
  );

  assign cur_req_ready = sel ? b_req_ready : a_req_ready;
  assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign cur_rdata     = sel ? b_rdata : a_rdata;
  assign cur_err       = sel ? b_err : a_err;

  typedef struct {
    logic        lw;
    logic        sw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One full transaction; inputs are scrambled while the request is in flight.
  task automatic run_txn(input bit s, input logic lw, input logic sw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int hold, input string nm);
    int n;
    logic [31:0] rd0;
    logic        er0;
    sel = s;
    @(negedge clk);
    n = 0;
    while (!cur_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_req_ready) begin
      chk({nm, " req_ready timeout"}, 32'(cur_req_ready), 32'd1);
      return;
    end
    lw_en = lw;
    sw_en = sw;
    addr  = a;
    wdata = wd;
    if (s) b_req_valid = 1'b1;
    else   a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lw_en = ~lw;
    sw_en = ~sw;
    addr  = ~a;
    wdata = ~wd;
    chk({nm, " busy req_ready"}, 32'(cur_req_ready), 32'd0);
    n = 0;
    while (!cur_rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), s ? 32'd1 : 32'd3);
    if (!cur_rsp_valid) return;
    chk({nm, " rdata"}, cur_rdata, exp_rd);
    chk({nm, " err"}, 32'(cur_err), 32'(exp_err));
    rd0 = cur_rdata;
    er0 = cur_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " hold rsp_valid"}, 32'(cur_rsp_valid), 32'd1);
      chk({nm, " hold rdata"}, cur_rdata, rd0);
      chk({nm, " hold err"}, 32'(cur_err), 32'(er0));
      chk({nm, " hold req_ready"}, 32'(cur_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, " post rsp_valid"}, 32'(cur_rsp_valid), 32'd0);
    chk({nm, " post req_ready"}, 32'(cur_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_1010, 32'h5555_5555, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h4000_0010, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0011, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

    rst = 1'b1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    rsp_ready = 1'b0;
    lw_en = 1'b0;
    sw_en = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    wstrb = 4'hF;
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(a_req_ready), 32'd1);
    chk("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("reset rdata", a_rdata, 32'h0);
    chk("reset err", 32'(a_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_txn(1'b0, vecs[i].lw, vecs[i].sw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
              vecs[i].exp_err, 0, $sformatf("vec%0d", i));
    end

    run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, "backpressure");

    // Store abandoned by reset while waiting must leave the RAM untouched.
    run_txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, 0, "pre store");
    run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "pre load");
    sel = 1'b0;
    @(negedge clk);
    lw_en = 1'b0;
    sw_en = 1'b1;
    addr = 32'h20;
    wdata = 32'h1234_5678;
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort req_ready", 32'(a_req_ready), 32'd1);
    chk("abort rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("abort rdata", a_rdata, 32'h0);
    chk("abort err", 32'(a_err), 32'd0);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (a_rsp_valid !== 1'b0) bad++;
    end
    chk("abort quiet", 32'(bad), 32'd0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 0, "abort reload");

    run_txn(1'b1, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 0, "w0 store");
    run_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 0, "w0 load");
    run_txn(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 2, "w0 misaligned");

`ifdef DMEM_BYTE_STRB_EN
    wstrb = 4'hF;
    run_txn(1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, "strb full");
    wstrb = 4'b0101;
    run_txn(1'b0, 1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 32'h0, 1'b0, 0, "strb partial");
    wstrb = 4'b0000;
    run_txn(1'b0, 1'b0, 1'b1, 32'h8, 32'h0000_0000, 32'h0, 1'b0, 0, "strb none");
    wstrb = 4'b0000;
    run_txn(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'hFFBB_FFDD, 1'b0, 0, "strb load");
    wstrb = 4'hF;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder: the RAM-side end of the load/store interface driven by the core's instruction decoder (`lw_en`, `sw_en`).
- Accepts one word load or store per transaction over a valid/ready request channel.
- Models a configurable number of wait states, then returns read data or an error on a valid/ready response channel.
- Sits between the core's memory stage and a word-organised internal RAM array.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; legal word index 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states between request acceptance and response; 0 is legal.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- lw_en  input  1  request is a word load.
- sw_en  input  1  request is a word store.
- addr  input  32  byte address.
- wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rdata  output  32  load data; 0 for stores and errors.
- err  output  1  request rejected; qualified by rsp_valid.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rdata=0, err=0, wait counter=0.
  - RAM contents are not cleared.
- Reset mid-operation: the pending transaction is abandoned. A store that has not yet committed (still in WAIT) is dropped and the RAM is unchanged.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid && req_ready at a clk edge.
  - At handshake, lw_en, sw_en, addr and wdata are captured. Input changes after acceptance are ignored.
  - Counter loads WAIT_CYCLES. Next state is WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each cycle while nonzero.
  - At the edge where the counter is 0: commit the access, latch rdata/err, go to RESP.
  - Result: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
- RESP:
  - rsp_valid=1; rdata and err held stable until the handshake.
  - On rsp_valid && rsp_ready: return to IDLE, clear rsp_valid. req_ready is 1 in the following cycle, so there is no back-to-back acceptance in the same cycle as the response handshake.
  - If rsp_ready stays low, the responder stays in RESP indefinitely.
- Error conditions (err=1, no RAM access, rdata=0):
  - lw_en and sw_en both 1, or both 0.
  - addr[1:0] != 0 (misaligned).
  - addr[31:2] >= DEPTH (out of range); the full 30-bit index is compared, with no wrap-around.
- Load: rdata = RAM[addr[31:2]], err=0.
- Store: RAM[addr[31:2]] = wdata at the commit edge, rdata=0, err=0.
- A load issued after a store to the same address returns the stored value.
- req_valid while not in IDLE: ignored, not queued. The core holds req_valid until req_ready.

Optional Feature:
- Macro: DMEM_BYTE_STRB_EN.
- Defined:
  - Adds input wstrb[3:0].
  - At commit, a store writes only the byte lanes whose wstrb bit is 1 (lane i = wdata[8i+7:8i]).
  - A store with wstrb=0 commits nothing but still responds with err=0.
  - Loads ignore wstrb.
- Undefined:
  - No wstrb port.
  - Stores always write all 4 bytes.

Test Plan:
- Reset, then store addr=0x10 wdata=0xDEADBEEF, then load addr=0x10 (WAIT_CYCLES=2) -> each rsp_valid is seen 3 cycles after acceptance. Store response is rdata=0, err=0; load response is rdata=0xDEADBEEF, err=0.
- Load addr=0x12 -> err=1, rdata=0, RAM unchanged. Load with lw_en=sw_en=1 at addr=0x0 -> err=1. Load addr=DEPTH*4 (0x1000) -> err=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stay constant and req_ready stays 0. Raise rsp_ready -> req_ready=1 the next cycle.
- Store 0x12345678 to 0x20 with rst pulsed 1 cycle after acceptance (in WAIT) -> outputs return to reset values; a later load of 0x20 returns the prior content (0 if never written).
- WAIT_CYCLES=0: load accepted at cycle N -> rsp_valid at N+1. Change addr/wdata while in WAIT -> the response reflects the captured values.
- DMEM_BYTE_STRB_EN: store 0xFFFFFFFF to 0x8, then store 0xAABBCCDD with wstrb=4'b0101 -> a load of 0x8 returns 0xFFBBFFDD.
